// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default parameters and derived depth shared by the sync_fifo slice
package sync_fifo_pkg;
  localparam int D_WIDTH_DEF   = 4;
  localparam int A_HEIGHT_DEF  = 4;
  localparam int AF_THRESH_DEF = 14;
  localparam int AE_THRESH_DEF = 2;
  localparam int DEPTH_DEF     = 1 << A_HEIGHT_DEF;
endpackage

// File: rtl/sync_fifo_ram.sv
// fifo_ram: simple dual-port array, synchronous write, registered enabled read
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int A_HEIGHT = A_HEIGHT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [A_HEIGHT-1:0] waddr,
  input  logic [D_WIDTH-1:0]  wdata,
  input  logic                re,
  input  logic [A_HEIGHT-1:0] raddr,
  output logic [D_WIDTH-1:0]  rdata
);
  logic [D_WIDTH-1:0] mem [1<<A_HEIGHT];
  // storage is never reset; a same-address read in this cycle sees the old word
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register holds its value unless a read is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised synchronous FIFO with count and threshold flags; SYNC_FIFO_ERR_EN adds sticky overflow/underflow
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int A_HEIGHT  = A_HEIGHT_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write,
  input  logic [D_WIDTH-1:0]  data_in,
  input  logic                read,
  output logic [D_WIDTH-1:0]  data_out,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [A_HEIGHT:0]   count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);
  localparam logic [A_HEIGHT:0] ONE   = {{A_HEIGHT{1'b0}}, 1'b1};
  localparam logic [A_HEIGHT:0] DEPTH = (A_HEIGHT+1)'(1 << A_HEIGHT);
  localparam logic [A_HEIGHT:0] AF_C  = (A_HEIGHT+1)'(AF_THRESH);
  localparam logic [A_HEIGHT:0] AE_C  = (A_HEIGHT+1)'(AE_THRESH);
  logic [A_HEIGHT:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  assign wr_acc = write & (~full | read);
  assign rd_acc = read & ~empty;
  assign full         = count == DEPTH;
  assign empty        = count == '0;
  assign almost_full  = count >= AF_C;
  assign almost_empty = count <= AE_C;
  // pointers wrap naturally over A_HEIGHT+1 bits; count tracks net accepted operations
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_acc ? wr_ptr + ONE : wr_ptr;
      rd_ptr <= rd_acc ? rd_ptr + ONE : rd_ptr;
      count  <= (wr_acc && !rd_acc) ? count + ONE : (rd_acc && !wr_acc) ? count - ONE : count;
    end
`ifdef SYNC_FIFO_ERR_EN
  // sticky error flags; a read paired with a write on an empty FIFO is not an underflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (write & full & ~read);
      underflow <= underflow | (read & empty & ~write);
    end
`endif
  fifo_ram #(.D_WIDTH(D_WIDTH), .A_HEIGHT(A_HEIGHT)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr[A_HEIGHT-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr[A_HEIGHT-1:0]),
    .rdata (data_out)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and randomized checks of sync_fifo against a queue model
module tb_sync_fifo;
  logic clk = 0, rst_n = 0, write = 0, read = 0;
  logic [3:0] data_in = 0;
  wire [3:0] data_out;
  wire full, empty, almost_full, almost_empty;
  wire [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  wire overflow, underflow;
`endif
  int total = 0, bad = 0;
  int q[$];
  logic [3:0] exp_dout = 0;
  bit exp_ov = 0, exp_uv = 0;
  always #5 clk = ~clk;
  sync_fifo #(.D_WIDTH(4), .A_HEIGHT(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .data_in(data_in), .read(read),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    int n;
    n = q.size();
    chk("dout", data_out, exp_dout);
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == 16);
    chk("afull", almost_full, n >= 14);
    chk("aempty", almost_empty, n <= 2);
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf", overflow, exp_ov);
    chk("unf", underflow, exp_uv);
`endif
  endtask
  task automatic model_reset();
    q.delete();
    exp_dout = 0;
    exp_ov = 0;
    exp_uv = 0;
  endtask
  task automatic step(bit w, bit r, logic [3:0] d);
    bit wa, ra;
    write = w; read = r; data_in = d;
    @(posedge clk);
    ra = r && q.size() > 0;
    wa = w && (q.size() < 16 || r);
    if (w && q.size() == 16 && !r) exp_ov = 1;
    if (r && q.size() == 0 && !w) exp_uv = 1;
    if (ra) exp_dout = 4'(q.pop_front());
    if (wa) q.push_back(int'(d));
    #1 check_all();
    @(negedge clk);
    write = 0; read = 0;
  endtask
  initial begin
    #1 check_all();
    repeat (2) @(negedge clk);
    rst_n = 1;
    step(0, 0, 0);
    step(1, 0, 10); step(1, 0, 5); step(1, 0, 6);
    chk("cnt3", count, 3);
    step(0, 1, 0); chk("rd10", data_out, 10);
    step(0, 1, 0); chk("rd5", data_out, 5);
    step(0, 1, 0); chk("rd6", data_out, 6);
    chk("empty_again", empty, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 4'(i));
      if (i == 12) chk("af_at13", almost_full, 0);
      if (i == 13) chk("af_at14", almost_full, 1);
      if (i == 14) chk("full_at15", full, 0);
    end
    chk("full_at16", full, 1);
    step(1, 0, 9);
    chk("drop_cnt", count, 16);
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf_set", overflow, 1);
`endif
    step(1, 1, 7);
    chk("full_rw_dout", data_out, 0);
    chk("full_rw_cnt", count, 16);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    chk("wrap_last", data_out, 7);
    step(1, 1, 3);
    chk("empty_rw_dout", data_out, 7);
    chk("empty_rw_cnt", count, 1);
`ifdef SYNC_FIFO_ERR_EN
    chk("empty_rw_unf", underflow, 0);
`endif
    step(0, 1, 0);
    chk("rd3", data_out, 3);
    for (int i = 1; i <= 6; i++) step(1, 0, 4'(i));
    step(0, 1, 0);
    chk("pre_rst_cnt", count, 5);
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    chk("rst_dout", data_out, 0);
    chk("rst_cnt", count, 0);
    @(negedge clk);
    rst_n = 1;
    step(0, 1, 0);
    chk("post_rst_rd", data_out, 0);
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 300) % 3;
      step($urandom_range(0, 3) < (ph == 0 ? 3 : ph == 1 ? 1 : 2),
           $urandom_range(0, 3) < (ph == 0 ? 1 : ph == 1 ? 3 : 2),
           4'($urandom_range(0, 15)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
